// File: rtl/ttl74163_countdown_ctrl_pkg.sv
// Shared definitions for the 74163/7448 countdown sequencer.
//  - state_t      : FSM encoding, 3 bits
//  - CNT_W        : counter / display digit width
//  - DISP_BLANK / DISP_ON : levels of the active-low decoder blanking line
//  - CNT_CLEARED  : shadow value of a cleared counter (Q=0 shown inverted)
//  - is_busy()    : states during which the sequencer owns the datapath
package ttl_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic DISP_BLANK = 1'b0;
  localparam logic DISP_ON    = 1'b1;

  localparam logic [CNT_W-1:0] CNT_CLEARED = '1;

  function automatic logic is_busy(input state_t s);
    return (s == S_LOAD) || (s == S_RUN) || (s == S_PAUSE);
  endfunction

endpackage

// File: rtl/ttl74163_countdown_ctrl_tick_prescaler.sv
// Count-step prescaler. Counts "counting cycles" modulo TICK_DIV.
//  CP      in  clock
//  rst     in  synchronous reset, active high
//  run     in  the cycle about to start is a counting cycle
//  restart in  zero the prescaler at this edge (has priority over run)
//  tick    out the counting cycle about to start is the last of a period
// tick is a look-ahead: the parent registers it so that its CE output is
// high during exactly the TICK_DIV-th counting cycle. With TICK_DIV=1 every
// counting cycle is a tick cycle.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CP,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  assign tick = run && !restart && (count == LAST);

  always_ff @(posedge CP) begin
    if (rst)          count <= '0;
    else if (restart) count <= '0;
    else if (run)     count <= tick ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/ttl74163_countdown_ctrl.sv
// Sequencer for a 74163 counter + 7448 decoder countdown display. The counter
// Q is inverted before decode, so counting up shows a falling digit.
//  CP         in  clock
//  rst        in  synchronous reset, active high
//  start      in  load preset and run (restarts when already running)
//  pause      in  hold the count while high in RUN
//  clear      in  synchronous clear of the counter
//  lamp_test  in  force all segments on
//  preset     in  [3:0] start digit
//  PEn        out counter parallel load, active low
//  CE         out counter enable (CEP and CET)
//  MRn        out counter synchronous clear, active low
//  D          out [3:0] counter parallel data (= ~preset)
//  LTN        out decoder lamp test, active low
//  BIN        out decoder blanking, active low
//  RBIN       out ripple blank in, tied high
//  cnt        out [3:0] shadow of the displayed digit (= ~Q)
//  busy       out LOAD/RUN/PAUSE
//  done       out DONE
// Control outputs are registered from the next state, so they are valid for
// the whole cycle the FSM spends in that state.
module ttl74163_countdown_ctrl
  import ttl_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter bit BLINK_EN    = 1'b1,
  parameter int BLINK_TICKS = 1
) (
  input  logic             CP,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             lamp_test,
  input  logic [CNT_W-1:0] preset,
  output logic             PEn,
  output logic             CE,
  output logic             MRn,
  output logic [CNT_W-1:0] D,
  output logic             LTN,
  output logic             BIN,
  output logic             RBIN,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] BLINK_LAST = 4'(BLINK_TICKS - 1);

  state_t     state, nxt;
  logic       tick, run, restart;
  logic [3:0] blink_cnt;

  // Prescaler advances on every RUN cycle, and on DONE cycles when blinking.
  assign run     = (nxt == S_RUN) || (BLINK_EN && (nxt == S_DONE));
  assign restart = (nxt == S_LOAD) || (nxt == S_CLR);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .CP      (CP),
    .rst     (rst),
    .run     (run),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge CP) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (clear)
      nxt = S_CLR;
    else if (start && (state inside {S_IDLE, S_RUN, S_PAUSE, S_DONE}))
      nxt = S_LOAD;
    else begin
      case (state)
        S_CLR:   nxt = S_IDLE;
        // D holds ~preset; all ones means a zero digit is being loaded.
        S_LOAD:  nxt = (D == '1) ? S_DONE : S_RUN;
        // Reaching zero beats pause: the counter steps on this edge anyway,
        // and a paused zero would wrap on resume.
        S_RUN: begin
          if (CE && (cnt == CNT_W'(1))) nxt = S_DONE;
          else if (pause)               nxt = S_PAUSE;
        end
        S_PAUSE: if (!pause) nxt = S_RUN;
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (rst) begin
      PEn       <= 1'b1;
      CE        <= 1'b0;
      MRn       <= 1'b1;
      D         <= '1;
      LTN       <= 1'b1;
      BIN       <= DISP_ON;
      cnt       <= CNT_CLEARED;
      busy      <= 1'b0;
      done      <= 1'b0;
      blink_cnt <= '0;
    end else begin
      PEn  <= (nxt != S_LOAD);
      MRn  <= (nxt != S_CLR);
      CE   <= (nxt == S_RUN) && tick;
      busy <= is_busy(nxt);
      done <= (nxt == S_DONE);
      LTN  <= ~lamp_test;
      if (nxt == S_LOAD) D <= ~preset;

      // Shadow follows what the physical counter does at this edge,
      // independent of where the FSM goes next.
      if (state == S_CLR)       cnt <= CNT_CLEARED;
      else if (state == S_LOAD) cnt <= ~D;
      else if (CE)              cnt <= cnt - 1'b1;

      if (BLINK_EN && (nxt == S_DONE)) begin
        if (tick) begin
          if (blink_cnt == BLINK_LAST) begin
            BIN       <= ~BIN;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end else begin
        BIN       <= DISP_ON;
        blink_cnt <= '0;
      end
    end
  end

  assign RBIN = DISP_ON;

endmodule

// File: tb/tb_ttl74163_countdown_ctrl.sv
module tb_ttl74163_countdown_ctrl;

  localparam int TD0 = 4, BT0 = 1;
  localparam int TD1 = 1, BT1 = 2;
  localparam int M_IDLE = 0, M_CLR = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4, M_DONE = 5;
  localparam logic [15:0] RST_V = {1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0};

  logic       CP = 1'b0;
  logic       rst = 1'b1, start = 1'b0, pause = 1'b0, clear = 1'b0, lamp_test = 1'b0;
  logic [3:0] preset = 4'd0;
  logic [1:0] pen, ce, mrn, ltn, bin, rbin, busy, done;
  logic [3:0] d [2];
  logic [3:0] cnt [2];

  always #5 CP = ~CP;

  ttl74163_countdown_ctrl #(.TICK_DIV(TD0), .BLINK_EN(1'b1), .BLINK_TICKS(BT0)) dut0 (
    .CP(CP), .rst(rst), .start(start), .pause(pause), .clear(clear), .lamp_test(lamp_test),
    .preset(preset), .PEn(pen[0]), .CE(ce[0]), .MRn(mrn[0]), .D(d[0]), .LTN(ltn[0]),
    .BIN(bin[0]), .RBIN(rbin[0]), .cnt(cnt[0]), .busy(busy[0]), .done(done[0]));

  ttl74163_countdown_ctrl #(.TICK_DIV(TD1), .BLINK_EN(1'b1), .BLINK_TICKS(BT1)) dut1 (
    .CP(CP), .rst(rst), .start(start), .pause(pause), .clear(clear), .lamp_test(lamp_test),
    .preset(preset), .PEn(pen[1]), .CE(ce[1]), .MRn(mrn[1]), .D(d[1]), .LTN(ltn[1]),
    .BIN(bin[1]), .RBIN(rbin[1]), .cnt(cnt[1]), .busy(busy[1]), .done(done[1]));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the panel should show, tracked as a mode, the
  // digit the physical counter holds, and the position inside the current
  // count period (counted in counting cycles).
  int m_mode [2], m_pos [2], m_cnt [2], m_d [2], m_blink [2];
  bit m_ce [2], m_ltn [2], m_bin [2];

  task automatic model_reset(input int i);
    m_mode[i] = M_IDLE; m_pos[i] = 0; m_cnt[i] = 15; m_d[i] = 15; m_blink[i] = 0;
    m_ce[i] = 0; m_ltn[i] = 1; m_bin[i] = 1;
  endtask

  task automatic model_step(input int i, input int td, input int bt);
    int  nm;
    bit  fin, tk;
    if (rst) begin model_reset(i); return; end
    fin = (m_mode[i] == M_RUN) && m_ce[i] && (m_cnt[i] == 1);
    // what the counter chip does at this edge
    if (m_mode[i] == M_CLR)       m_cnt[i] = 15;
    else if (m_mode[i] == M_LOAD) m_cnt[i] = 15 - m_d[i];
    else if (m_ce[i])             m_cnt[i] = (m_cnt[i] + 15) % 16;
    nm = m_mode[i];
    if (clear) nm = M_CLR;
    else if (start && m_mode[i] != M_CLR && m_mode[i] != M_LOAD) nm = M_LOAD;
    else if (m_mode[i] == M_CLR) nm = M_IDLE;
    else if (m_mode[i] == M_LOAD) nm = (m_cnt[i] == 0) ? M_DONE : M_RUN;
    else if (m_mode[i] == M_RUN) nm = fin ? M_DONE : (pause ? M_PAUSE : M_RUN);
    else if (m_mode[i] == M_PAUSE) nm = pause ? M_PAUSE : M_RUN;
    m_ce[i] = 0;
    if (nm == M_LOAD) begin m_d[i] = 15 - int'(preset); m_pos[i] = 0; end
    if (nm == M_CLR) m_pos[i] = 0;
    if (nm == M_RUN || nm == M_DONE) begin
      tk = (m_pos[i] == td - 1);
      m_pos[i] = (m_pos[i] + 1) % td;
      if (nm == M_RUN) m_ce[i] = tk;
      else if (tk) begin
        m_blink[i]++;
        if (m_blink[i] == bt) begin m_bin[i] = !m_bin[i]; m_blink[i] = 0; end
      end
    end
    if (nm != M_DONE) begin m_bin[i] = 1; m_blink[i] = 0; end
    m_ltn[i] = !lamp_test;
    m_mode[i] = nm;
  endtask

  function automatic logic [15:0] obs(input int i);
    return {pen[i], ce[i], mrn[i], d[i], ltn[i], bin[i], rbin[i], cnt[i], busy[i], done[i]};
  endfunction

  function automatic logic [15:0] expv(input int i);
    logic [3:0] dd, cc;
    dd = 4'(m_d[i]);
    cc = 4'(m_cnt[i]);
    return {m_mode[i] != M_LOAD, m_ce[i], m_mode[i] != M_CLR, dd, m_ltn[i], m_bin[i], 1'b1, cc,
            (m_mode[i] == M_LOAD || m_mode[i] == M_RUN || m_mode[i] == M_PAUSE),
            m_mode[i] == M_DONE};
  endfunction

  int cyc = 0;

  task automatic cycle();
    @(posedge CP);
    model_step(0, TD0, BT0);
    model_step(1, TD1, BT1);
    @(negedge CP);
    cyc++;
    chk("outs0", obs(0), expv(0));
    chk("outs1", obs(1), expv(1));
  endtask

  task automatic pulse_start(input logic [3:0] p);
    preset = p; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    int n, last, run_len, max_run, prev_bin, toggles;
    bit seen;
    model_reset(0); model_reset(1);

    // 1. reset
    rst = 1'b1;
    cycle(); cycle();
    chk("rst_vec0", obs(0), RST_V);
    chk("rst_vec1", obs(1), RST_V);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin cycle(); n += ce[0] + ce[1]; end
    chk("idle_no_ce", n, 0);

    // 2. preset 3 countdown
    pulse_start(4'd3);
    chk("load_pen", pen[0], 1'b0);
    chk("load_d", d[0], 4'hC);
    n = 0; last = -1; seen = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (ce[0]) begin
        if (last >= 0) chk("ce_period", cyc - last, 4);
        last = cyc; n++;
      end
    end
    chk("ce_count3", n, 3);
    chk("done3", done[0], 1'b1);
    chk("cnt3", cnt[0], 4'd0);

    // 3. pause after first CE
    pulse_start(4'd5);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin cycle(); seen = ce[0]; end
    chk("first_ce_seen", seen, 1'b1);
    pause = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin cycle(); n += ce[0]; end
    chk("ce_while_paused", n, 0);
    chk("paused_busy", busy[0], 1'b1);
    pause = 1'b0;
    for (int k = 0; k < 40 && !done[0]; k++) cycle();
    chk("pause_done", done[0], 1'b1);
    chk("pause_cnt", cnt[0], 4'd0);

    // 4. start and clear together during RUN
    pulse_start(4'd9);
    for (int k = 0; k < 6; k++) cycle();
    start = 1'b1; clear = 1'b1;
    cycle();
    start = 1'b0; clear = 1'b0;
    chk("clr_mrn", mrn[0], 1'b0);
    chk("clr_pen", pen[0], 1'b1);
    chk("clr_ce", ce[0], 1'b0);
    cycle();
    chk("clr_idle", {busy[0], done[0], mrn[0]}, 3'b001);
    chk("clr_cnt", cnt[0], 4'd15);

    // 5. preset 0 goes straight to DONE and blinks
    pulse_start(4'd0);
    chk("z_load", pen[0], 1'b0);
    cycle();
    chk("z_done", done[0], 1'b1);
    n = 0; last = -1; toggles = 0; prev_bin = bin[0];
    for (int k = 0; k < 20; k++) begin
      cycle();
      n += ce[0];
      if (bin[0] != prev_bin) begin
        if (last >= 0) chk("blink_period", cyc - last, 4);
        last = cyc; toggles++;
      end
      prev_bin = bin[0];
    end
    chk("z_no_ce", n, 0);
    chk("z_toggles", toggles >= 4, 1'b1);

    // 6. TICK_DIV=1 instance, preset 15, lamp test mid-run
    pulse_start(4'd15);
    n = 0; run_len = 0; max_run = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 6) lamp_test = 1'b1;
      cycle();
      if (k == 6) begin
        chk("lamp_ltn", ltn[1], 1'b0);
        lamp_test = 1'b0;
      end
      if (ce[1]) begin n++; run_len++; if (run_len > max_run) max_run = run_len; end
      else run_len = 0;
    end
    chk("td1_ce_count", n, 15);
    chk("td1_ce_consec", max_run, 15);
    chk("td1_done", {done[1], cnt[1]}, 5'h10);
    chk("ltn_back", ltn[1], 1'b1);

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 149) == 0);
      clear     = ($urandom_range(0, 39) == 0);
      start     = ($urandom_range(0, 17) == 0);
      lamp_test = ($urandom_range(0, 9) == 0);
      preset    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
